// File: rtl/tipd_pkg.sv
// Shared constants for the I-PD sample sequencer: FSM state codes and duty limits.
package tipd_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADC_REQ   = 3'd1;
  localparam logic [2:0] ST_ADC_WAIT  = 3'd2;
  localparam logic [2:0] ST_PID_START = 3'd3;
  localparam logic [2:0] ST_PID_WAIT  = 3'd4;
  localparam logic [2:0] ST_UPDATE    = 3'd5;
  localparam logic [2:0] ST_FAULT     = 3'd6;

  localparam logic [7:0] DUTY_MIN = 8'd0;
  localparam logic [7:0] DUTY_MAX = 8'd255;

endpackage

// File: rtl/tipd_tick_gen.sv
// Sample-period tick: counts 0..PERIOD-1 while enabled, held at 0 otherwise,
// and flags the last count so the sequencer can start a new sample.
module tipd_tick_gen
  import tipd_pkg::*;
#(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  output logic o_tick
);

  localparam int              CW   = $clog2(PERIOD);
  localparam logic [CW-1:0]   LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_enable || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/tipd_sequencer.sv
// Per-period sequencer: ADC request -> position latch -> I-PD start -> saturated
// duty update, with handshake timeouts and sticky fault/overrun flags.
module tipd_sequencer
  import tipd_pkg::*;
#(
  parameter int ANCHO   = 19,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    adc_start,
  input  logic                    adc_done,
  input  logic [7:0]              adc_data,
  output logic [7:0]              yk,
  output logic                    ready_data,
  input  logic                    suma_ready,
  input  logic signed [ANCHO-1:0] suma_in,
  output logic [7:0]              duty,
  output logic                    duty_valid,
  output logic                    busy,
  output logic                    fault,
  output logic                    overrun,
  input  logic                    fault_clr
);

  localparam int                      WW       = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]           WAIT_END = WW'(TIMEOUT - 1);
  localparam logic signed [ANCHO-1:0] SAT_HI   = {{(ANCHO-8){1'b0}}, DUTY_MAX};

  logic [2:0]    r_state;
  logic [WW-1:0] r_wait;
  logic [7:0]    r_sat;
  logic [7:0]    r_yk;
  logic [7:0]    r_duty;
  logic          r_adc_start;
  logic          r_ready_data;
  logic          r_duty_valid;
  logic          r_fault;
  logic          r_overrun;
  logic          w_tick;
  logic          w_busy;

  function automatic logic [7:0] sat8(input logic signed [ANCHO-1:0] v);
    if (v[ANCHO-1]) begin
      return DUTY_MIN;
    end else if (v > SAT_HI) begin
      return DUTY_MAX;
    end else begin
      return v[7:0];
    end
  endfunction

  tipd_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  assign w_busy = (r_state != ST_IDLE) && (r_state != ST_FAULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_wait       <= '0;
      r_sat        <= DUTY_MIN;
      r_yk         <= 8'd0;
      r_duty       <= DUTY_MIN;
      r_adc_start  <= 1'b0;
      r_ready_data <= 1'b0;
      r_duty_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_adc_start  <= 1'b0;
      r_ready_data <= 1'b0;
      r_duty_valid <= 1'b0;

      // A clear always wins over a same-cycle overrun; ticks while idle or faulted are harmless.
      if (fault_clr) begin
        r_fault   <= 1'b0;
        r_overrun <= 1'b0;
      end else if (w_tick && w_busy) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_ADC_REQ;
          end
        end
        ST_ADC_REQ: begin
          r_adc_start <= 1'b1;
          r_wait      <= '0;
          r_state     <= ST_ADC_WAIT;
        end
        ST_ADC_WAIT: begin
          if (adc_done) begin
            r_yk    <= adc_data;
            r_state <= ST_PID_START;
          end else if (r_wait == WAIT_END) begin
            r_fault <= 1'b1;
            r_duty  <= DUTY_MIN;
            r_state <= ST_FAULT;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        ST_PID_START: begin
          r_ready_data <= 1'b1;
          r_wait       <= '0;
          r_state      <= ST_PID_WAIT;
        end
        ST_PID_WAIT: begin
          if (suma_ready) begin
            r_sat   <= sat8(suma_in);
            r_state <= ST_UPDATE;
          end else if (r_wait == WAIT_END) begin
            r_fault <= 1'b1;
            r_duty  <= DUTY_MIN;
            r_state <= ST_FAULT;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        ST_UPDATE: begin
          r_duty       <= r_sat;
          r_duty_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        ST_FAULT: begin
          r_duty <= DUTY_MIN;
          if (fault_clr) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign adc_start  = r_adc_start;
  assign ready_data = r_ready_data;
  assign duty_valid = r_duty_valid;
  assign yk         = r_yk;
  assign duty       = r_duty;
  assign fault      = r_fault;
  assign overrun    = r_overrun;
  assign busy       = w_busy;

endmodule

// File: tb/tb_tipd_sequencer.sv
// Directed bench for tipd_sequencer with PERIOD=20: normal samples, saturation
// corners, stray pulses, overrun, timeout/fault recovery, enable drop and reset.
module tb_tipd_sequencer;

  localparam int ANCHO   = 19;
  localparam int PERIOD  = 20;
  localparam int TIMEOUT = 64;
  localparam int CLK_NS  = 10;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    enable = 1'b0;
  logic                    adc_start;
  logic                    adc_done = 1'b0;
  logic [7:0]              adc_data = 8'h00;
  logic [7:0]              yk;
  logic                    ready_data;
  logic                    suma_ready = 1'b0;
  logic signed [ANCHO-1:0] suma_in = '0;
  logic [7:0]              duty;
  logic                    duty_valid;
  logic                    busy;
  logic                    fault;
  logic                    overrun;
  logic                    fault_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int dv_count = 0;
  int rd_count = 0;
  time t_dv = 0;
  time t_dv_prev = 0;

  tipd_sequencer #(
    .ANCHO   (ANCHO),
    .PERIOD  (PERIOD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .adc_start  (adc_start),
    .adc_done   (adc_done),
    .adc_data   (adc_data),
    .yk         (yk),
    .ready_data (ready_data),
    .suma_ready (suma_ready),
    .suma_in    (suma_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .busy       (busy),
    .fault      (fault),
    .overrun    (overrun),
    .fault_clr  (fault_clr)
  );

  always #(CLK_NS/2) clk = ~clk;

  always @(posedge clk) begin
    if (duty_valid === 1'b1) dv_count <= dv_count + 1;
    if (ready_data === 1'b1) rd_count <= rd_count + 1;
  end

  initial begin
    #(CLK_NS * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", tag, $signed(got), $time);
    end
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      0:       return adc_start;
      1:       return ready_data;
      2:       return duty_valid;
      default: return fault;
    endcase
  endfunction

  // Returns the index of the first negedge (1-based) at which the signal is high, or -1.
  task automatic wait_sig(input int sel, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (sig_sel(sel) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_sample(input bit skip_wait, input logic [7:0] data, input int adc_lat,
                           input logic signed [ANCHO-1:0] s, input int pid_lat,
                           input logic [7:0] exp_duty, output int n_start);
    n_start = 0;
    if (!skip_wait) begin
      wait_sig(0, 60, n_start);
      if (n_start < 0) begin
        check_val("adc_start_seen", 32'd0, 32'd1);
        return;
      end
    end
    repeat (adc_lat) begin
      @(negedge clk);
      fault_clr = 1'b0;
    end
    adc_done = 1'b1;
    adc_data = data;
    @(negedge clk);
    adc_done = 1'b0;
    adc_data = 8'h00;
    check_val("ready_data_early", {31'd0, ready_data}, 32'd0);
    check_val("yk", {24'd0, yk}, {24'd0, data});
    @(negedge clk);
    check_val("ready_data", {31'd0, ready_data}, 32'd1);
    check_val("busy", {31'd0, busy}, 32'd1);
    repeat (pid_lat) @(negedge clk);
    suma_ready = 1'b1;
    suma_in    = s;
    @(negedge clk);
    suma_ready = 1'b0;
    suma_in    = '0;
    check_val("duty_valid_early", {31'd0, duty_valid}, 32'd0);
    @(negedge clk);
    check_val("duty_valid", {31'd0, duty_valid}, 32'd1);
    check_val("duty", {24'd0, duty}, {24'd0, exp_duty});
    t_dv_prev = t_dv;
    t_dv      = $time;
    @(negedge clk);
    check_val("duty_valid_single", {31'd0, duty_valid}, 32'd0);
  endtask

  logic [7:0]              vec_data [9] = '{8'h5A, 8'h33, 8'hA5, 8'h0F, 8'h77, 8'h01, 8'hC3, 8'h3C, 8'h80};
  logic signed [ANCHO-1:0] vec_suma [9] = '{19'sd100, -19'sd5, 19'sd300, 19'sd255, 19'sd256,
                                            19'sd0, 19'sd262143, -19'sd262144, 19'sd1};
  logic [7:0]              vec_duty [9] = '{8'd100, 8'd0, 8'd255, 8'd255, 8'd255,
                                            8'd0, 8'd255, 8'd0, 8'd1};

  initial begin
    int n;
    int dv_b;
    int rd_b;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_adc_start", {31'd0, adc_start}, 32'd0);
    check_val("rst_ready_data", {31'd0, ready_data}, 32'd0);
    check_val("rst_duty_valid", {31'd0, duty_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_fault", {31'd0, fault}, 32'd0);
    check_val("rst_overrun", {31'd0, overrun}, 32'd0);
    check_val("rst_yk", {24'd0, yk}, 32'd0);
    check_val("rst_duty", {24'd0, duty}, 32'd0);

    // Release with enable high: tick after PERIOD cycles, adc_start one cycle later
    rst    = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      do_sample(1'b0, vec_data[k], 3, vec_suma[k], 10, vec_duty[k], n);
      if (k == 0) begin
        check_val("first_start_delay", n, PERIOD + 1);
        // Stray handshakes while idle must be ignored
        adc_done   = 1'b1;
        adc_data   = 8'hFF;
        suma_ready = 1'b1;
        suma_in    = 19'sd7;
        @(negedge clk);
        adc_done   = 1'b0;
        adc_data   = 8'h00;
        suma_ready = 1'b0;
        suma_in    = '0;
        check_val("stray_yk", {24'd0, yk}, 32'h5A);
        check_val("stray_duty", {24'd0, duty}, 32'd100);
      end else begin
        check_val("dv_spacing", 32'(t_dv - t_dv_prev), 32'(PERIOD * CLK_NS));
      end
    end
    check_val("no_overrun_normal", {31'd0, overrun}, 32'd0);

    // Late suma_ready: tick during PID_WAIT sets overrun and is dropped
    do_sample(1'b0, 8'h44, 3, 19'sd120, 25, 8'd120, n);
    check_val("overrun_set", {31'd0, overrun}, 32'd1);
    wait_sig(0, 40, n);
    check_val("next_start_after_overrun", n, 7);
    // fault_clr outside FAULT: flags clear, sample continues
    fault_clr = 1'b1;
    do_sample(1'b1, 8'h55, 3, 19'sd60, 10, 8'd60, n);
    check_val("overrun_cleared", {31'd0, overrun}, 32'd0);

    // ADC timeout -> FAULT
    wait_sig(0, 40, n);
    rd_b = rd_count;
    wait_sig(3, 100, n);
    check_val("timeout_cycles", n, TIMEOUT);
    check_val("fault_set", {31'd0, fault}, 32'd1);
    check_val("fault_duty", {24'd0, duty}, 32'd0);
    check_val("fault_busy", {31'd0, busy}, 32'd0);
    check_val("fault_overrun", {31'd0, overrun}, 32'd1);
    check_val("fault_no_ready", rd_count, rd_b);
    wait_sig(0, 14, n);
    check_val("fault_no_start", n, -1);
    // fault_clr coincides with a tick: tick dropped, overrun stays clear
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_val("fault_clr_fault", {31'd0, fault}, 32'd0);
    check_val("fault_clr_overrun", {31'd0, overrun}, 32'd0);
    check_val("fault_clr_busy", {31'd0, busy}, 32'd0);
    wait_sig(0, 40, n);
    check_val("start_after_fault", n, PERIOD + 1);
    do_sample(1'b1, 8'h21, 3, 19'sd42, 10, 8'd42, n);

    // enable drops mid-sample: sample completes, nothing new starts
    wait_sig(0, 40, n);
    enable = 1'b0;
    dv_b = dv_count;
    do_sample(1'b1, 8'h66, 3, 19'sd77, 10, 8'd77, n);
    wait_sig(0, 60, n);
    check_val("no_start_disabled", n, -1);
    check_val("one_dv_disabled", dv_count, dv_b + 1);

    // Reset during PID_WAIT
    enable = 1'b1;
    wait_sig(0, 40, n);
    check_val("start_after_enable", n, PERIOD + 1);
    repeat (3) @(negedge clk);
    adc_done = 1'b1;
    adc_data = 8'h99;
    @(negedge clk);
    adc_done = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("arst_yk", {24'd0, yk}, 32'd0);
    check_val("arst_duty", {24'd0, duty}, 32'd0);
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_ready_data", {31'd0, ready_data}, 32'd0);
    check_val("arst_adc_start", {31'd0, adc_start}, 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    dv_b = dv_count;
    @(negedge clk);
    @(negedge clk);
    suma_ready = 1'b1;
    suma_in    = 19'sd123;
    @(negedge clk);
    suma_ready = 1'b0;
    suma_in    = '0;
    wait_sig(0, 40, n);
    check_val("start_after_reset", n, PERIOD - 2);
    check_val("late_suma_ignored", dv_count, dv_b);
    check_val("late_suma_duty", {24'd0, duty}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tipd_sequencer.md
TIPD_SEQUENCER -- requirements
Module: tipd_sequencer

Interface
REQ-001 Parameter ANCHO, default 19: width of the signed I-PD sum input.
REQ-002 Parameter PERIOD, default 1000: sample period in clk cycles, minimum 8.
REQ-003 Parameter TIMEOUT, default 64: maximum wait cycles in any handshake state.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  high allows new samples to start.
REQ-007 adc_start  out  1  one-cycle request to the position sensor/ADC.
REQ-008 adc_done  in  1  one-cycle pulse; adc_data is valid in the same cycle.
REQ-009 adc_data  in  8  measured position.
REQ-010 yk  out  8  latched position sample, driven to the I-PD datapath.
REQ-011 ready_data  out  1  one-cycle start pulse to the I-PD datapath.
REQ-012 suma_ready  in  1  one-cycle pulse; suma_in is valid in the same cycle.
REQ-013 suma_in  in  ANCHO  signed two's-complement I-PD output.
REQ-014 duty  out  8  saturated PWM duty command.
REQ-015 duty_valid  out  1  one-cycle pulse when duty updates.
REQ-016 busy  out  1  high in any state except IDLE and FAULT.
REQ-017 fault  out  1  sticky handshake-timeout flag.
REQ-018 overrun  out  1  sticky flag: a period tick arrived while busy.
REQ-019 fault_clr  in  1  clears fault, overrun and the FAULT state.

Function
REQ-020 Tick generator: counter 0..PERIOD-1 that advances only while enable=1, is forced to 0 while enable=0, and asserts tick for one cycle at PERIOD-1 before wrapping to 0.
REQ-021 States: IDLE, ADC_REQ, ADC_WAIT, PID_START, PID_WAIT, UPDATE, FAULT.
REQ-022 IDLE: on tick -> ADC_REQ; otherwise stay.
REQ-023 ADC_REQ: assert adc_start for exactly one cycle -> ADC_WAIT.
REQ-024 ADC_WAIT: on adc_done, latch adc_data into yk -> PID_START.
REQ-025 PID_START: assert ready_data for exactly one cycle with yk already stable -> PID_WAIT.
REQ-026 PID_WAIT: on suma_ready, register sat(suma_in) -> UPDATE.
REQ-027 UPDATE: drive duty from the registered value, pulse duty_valid for one cycle -> IDLE.
REQ-028 Saturation: suma_in<0 -> 0; suma_in>255 -> 255; otherwise the low 8 bits; the comparison is signed over the full ANCHO width.
REQ-029 Latency: adc_done to ready_data = 2 cycles; suma_ready to duty_valid = 2 cycles.
REQ-030 Wait counter is cleared on entry to ADC_WAIT and PID_WAIT; reaching TIMEOUT with no done pulse -> FAULT, fault=1, duty=0.
REQ-031 FAULT: adc_start, ready_data and duty_valid stay low, duty stays 0; fault_clr=1 -> IDLE.
REQ-032 A tick in any busy state sets overrun and is dropped; the current sample completes normally.
REQ-033 enable falling mid-sample: the current sample completes and no new sample starts.
REQ-034 Stray adc_done or suma_ready outside its wait state is ignored.
REQ-035 fault_clr together with a tick in FAULT: go to IDLE, tick dropped, overrun not set.
REQ-036 fault_clr outside FAULT clears fault and overrun only and leaves the state unchanged.

Reset
REQ-037 rst=0 asynchronously forces IDLE, counters=0, yk=0, duty=0, and adc_start, ready_data, duty_valid, busy, fault, overrun all 0.
REQ-038 Reset mid-sample abandons the sample; after release the first tick occurs PERIOD cycles after enable is high.

Structure
REQ-039 Shared package tipd_pkg holds the state encodings, DUTY_MIN=0 and DUTY_MAX=255.
REQ-040 One sub-module, tipd_tick_gen, holds the period counter and tick output; the FSM, wait counter and saturation live in tipd_sequencer.

Verification
REQ-041 PERIOD=20, enable=1, adc_done 3 cycles after adc_start with data 0x5A, suma_ready 10 cycles after ready_data with suma_in=+100 -> yk=0x5A, duty=100, one duty_valid per 20 cycles.
REQ-042 suma_in=-5 -> duty=0; suma_in=+300 -> duty=255; suma_in=+255 -> duty=255.
REQ-043 adc_done withheld for 64 cycles -> FAULT, fault=1, duty=0, no ready_data; fault_clr pulse -> IDLE, next tick starts a sample.
REQ-044 suma_ready delayed 25 cycles with PERIOD=20 -> overrun=1, that sample completes, the next sample starts on the following tick.
REQ-045 rst pulsed low during PID_WAIT -> all outputs 0 immediately; a late suma_ready after release is ignored.
REQ-046 enable dropped during ADC_WAIT -> sample completes with one duty_valid, then no further adc_start.
